// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the bus-attached load/store unit.
// Holds the mem_op encodings, the FSM state constants and the helpers
// that turn a mem_op into an access size and signedness.
package lsu_pkg;

  // mem_op encodings; 1..4 sign-extend on load, 5..7 zero-extend
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_B    = 3'd1;
  localparam logic [2:0] OP_H    = 3'd2;
  localparam logic [2:0] OP_W    = 3'd3;
  localparam logic [2:0] OP_D    = 3'd4;
  localparam logic [2:0] OP_BU   = 3'd5;
  localparam logic [2:0] OP_HU   = 3'd6;
  localparam logic [2:0] OP_WU   = 3'd7;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [3:0] bytes;
    logic       is_signed;
  } size_info_t;

  // Byte count of an access; 0 for a non-memory op
  function automatic logic [3:0] op_bytes(input logic [2:0] op);
    logic [3:0] n;
    case (op)
      OP_B, OP_BU: n = 4'd1;
      OP_H, OP_HU: n = 4'd2;
      OP_W, OP_WU: n = 4'd4;
      OP_D:        n = 4'd8;
      default:     n = 4'd0;
    endcase
    return n;
  endfunction

  // Full size decode: byte count plus whether a load sign-extends
  function automatic size_info_t decode_size(input logic [2:0] op);
    size_info_t s;
    s.bytes     = op_bytes(op);
    s.is_signed = (op != OP_NONE) && (op <= OP_D);
    return s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane steering for the LSU.
// Ports:
//   addr_lo    - byte offset of the access inside the bus word
//   mem_op     - access encoding (size and signedness)
//   wdata      - right-aligned store data
//   rsp_data   - full-width read data from the bus
//   lane_wdata - store data moved to its byte lane
//   lane_wstrb - byte strobes covering the accessed bytes
//   load_data  - read data extracted and sign/zero extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int STRB_W = XLEN / 8,
  localparam int OFF_W = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  addr_lo,
  input  logic [2:0]        mem_op,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rsp_data,
  output logic [XLEN-1:0]   lane_wdata,
  output logic [STRB_W-1:0] lane_wstrb,
  output logic [XLEN-1:0]   load_data
);

  localparam int SH_W = $clog2(XLEN);

  size_info_t        sz;
  logic [SH_W-1:0]   bit_shift;
  logic [STRB_W:0]   strb_base;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   keep_mask;
  logic [SH_W-1:0]   msb_idx;
  logic              sign_bit;

  assign sz        = decode_size(mem_op);
  assign bit_shift = {addr_lo, 3'b000};

  // One extra strobe bit so a full-width access still yields all ones
  assign strb_base  = ((STRB_W+1)'(1) << sz.bytes) - (STRB_W+1)'(1);
  assign lane_wstrb = strb_base[STRB_W-1:0] << addr_lo;
  assign lane_wdata = wdata << bit_shift;

  assign shifted = rsp_data >> bit_shift;

  // Keep the low size-many bytes and fill the rest with the sign bit
  // (or zeros); full-width accesses pass through untouched
  always_comb begin
    keep_mask = '1;
    msb_idx   = '0;
    sign_bit  = 1'b0;
    if ((sz.bytes != 4'd0) && (int'(sz.bytes) < STRB_W)) begin
      keep_mask = (XLEN'(1) << {sz.bytes, 3'b000}) - XLEN'(1);
      msb_idx   = SH_W'({sz.bytes, 3'b000} - 7'd1);
      sign_bit  = sz.is_signed & shifted[msb_idx];
    end
    load_data = (shifted & keep_mask) | (sign_bit ? ~keep_mask : '0);
  end

endmodule

// File: rtl/lsu_bus.sv
// lsu_bus: multi-cycle load/store unit between the EXU and WBU stages.
// Ports:
//   clk, rst             - clock and asynchronous active-low reset
//   exu_valid/lsu_ready  - EXU handshake; operation fields captured on accept
//   addr, wdata, mem_op, we, sb_i - operation and its sideband
//   lsu_valid/wb_ready   - WBU handshake; result held until accepted
//   dataout, alures_o, sb_o, misalign_o, bus_err_o, mmio_o - result
//   req_*                - memory request channel (valid/ready)
//   rsp_valid, rsp_data, rsp_err - memory response channel (always accepted)
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter int          SB_W       = 128,
  parameter logic [63:0] MMIO_BASE  = 64'h0200_0000,
  parameter logic [63:0] MMIO_LIMIT = 64'h0200_BFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              lsu_ready,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [2:0]        mem_op,
  input  logic              we,
  input  logic [SB_W-1:0]   sb_i,
  output logic              lsu_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   dataout,
  output logic [XLEN-1:0]   alures_o,
  output logic [SB_W-1:0]   sb_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              mmio_o,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [XLEN-1:0]   req_addr,
  output logic              req_we,
  output logic [XLEN-1:0]   req_wdata,
  output logic [XLEN/8-1:0] req_wstrb,
  output logic              req_mmio,
  input  logic              rsp_valid,
  input  logic [XLEN-1:0]   rsp_data,
  input  logic              rsp_err
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [1:0]      state;
  logic [XLEN-1:0] op_addr;
  logic [XLEN-1:0] op_wdata;
  logic [2:0]      op_mem_op;
  logic            op_we;

  logic            accept;
  logic [3:0]      in_bytes;
  logic            in_misalign;
  logic [63:0]     addr_wide;
  logic            in_mmio;
  logic            is_store;
  logic [XLEN-1:0] load_data;

  assign lsu_ready = (state == ST_IDLE) || ((state == ST_DONE) && wb_ready);
  assign accept    = exu_valid && lsu_ready;
  assign lsu_valid = (state == ST_DONE);
  assign req_valid = (state == ST_REQ);

  // An access wider than the bus (D on a 32-bit bus) can never be aligned
  assign in_bytes    = op_bytes(mem_op);
  assign in_misalign = (int'(in_bytes) > STRB_W) ||
                       ((addr & (XLEN'(in_bytes) - XLEN'(1))) != '0);

  assign addr_wide = 64'(addr);
  assign in_mmio   = (addr_wide >= MMIO_BASE) && (addr_wide <= MMIO_LIMIT);

  // we only means store for the signed encodings; 5..7 are always loads
  assign is_store = op_we && (op_mem_op != OP_NONE) && (op_mem_op <= OP_D);

  assign alures_o = op_addr;
  assign req_addr = {op_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign req_we   = is_store;
  assign req_mmio = mmio_o;

  lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo    (op_addr[OFF_W-1:0]),
    .mem_op     (op_mem_op),
    .wdata      (op_wdata),
    .rsp_data   (rsp_data),
    .lane_wdata (req_wdata),
    .lane_wstrb (req_wstrb),
    .load_data  (load_data)
  );

  // Operation capture and FSM. Accept is only possible in IDLE or in DONE
  // with wb_ready, so it takes priority over the per-state transitions and
  // gives back-to-back issue straight out of DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_addr    <= '0;
      op_wdata   <= '0;
      op_mem_op  <= OP_NONE;
      op_we      <= 1'b0;
      sb_o       <= '0;
      dataout    <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      mmio_o     <= 1'b0;
    end else if (accept) begin
      op_addr   <= addr;
      op_wdata  <= wdata;
      op_mem_op <= mem_op;
      op_we     <= we;
      sb_o      <= sb_i;
      dataout   <= '0;
      bus_err_o <= 1'b0;
      mmio_o    <= in_mmio;
      if (mem_op == OP_NONE) begin
        misalign_o <= 1'b0;
        state      <= ST_DONE;
      end else if (in_misalign) begin
        misalign_o <= 1'b1;
        state      <= ST_DONE;
      end else begin
        misalign_o <= 1'b0;
        state      <= ST_REQ;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rsp_valid) begin
            dataout   <= is_store ? '0 : load_data;
            bus_err_o <= rsp_err;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (wb_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: self-checking bench for lsu_bus (XLEN = 64).
// Directed scenarios plus randomized operations compared against a
// byte-level reference model of loads, stores, alignment and MMIO decode.
module tb_lsu_bus;

  localparam int XLEN = 64;
  localparam int SB_W = 128;
  localparam logic [63:0] MBASE  = 64'h0200_0000;
  localparam logic [63:0] MLIMIT = 64'h0200_BFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            exu_valid;
  logic            lsu_ready;
  logic [63:0]     addr;
  logic [63:0]     wdata;
  logic [2:0]      mem_op;
  logic            we;
  logic [127:0]    sb_i;
  logic            lsu_valid;
  logic            wb_ready;
  logic [63:0]     dataout;
  logic [63:0]     alures_o;
  logic [127:0]    sb_o;
  logic            misalign_o;
  logic            bus_err_o;
  logic            mmio_o;
  logic            req_valid;
  logic            req_ready;
  logic [63:0]     req_addr;
  logic            req_we;
  logic [63:0]     req_wdata;
  logic [7:0]      req_wstrb;
  logic            req_mmio;
  logic            rsp_valid;
  logic [63:0]     rsp_data;
  logic            rsp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_bus #(.XLEN(XLEN), .SB_W(SB_W), .MMIO_BASE(MBASE), .MMIO_LIMIT(MLIMIT)) dut (
    .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
    .addr(addr), .wdata(wdata), .mem_op(mem_op), .we(we), .sb_i(sb_i),
    .lsu_valid(lsu_valid), .wb_ready(wb_ready), .dataout(dataout),
    .alures_o(alures_o), .sb_o(sb_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o), .mmio_o(mmio_o), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_mmio(req_mmio),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Reference model helpers
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      3'd3, 3'd7: return 4;
      3'd4:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input int off,
                                             input int size, input bit sgn);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < size; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (sgn && r[8*size-1])
      for (int i = size; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] wd, input int off);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i + off < 8; i++) r[8*(i+off) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [7:0] model_strb(input int off, input int size);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < size; i++) r[off+i] = 1'b1;
    return r;
  endfunction

  // Issue one operation and act as the bus until lsu_valid rises.
  // Returns with lsu_valid high and wb_ready low; cycles = -1 on timeout.
  task automatic run_op(input logic [63:0] a, input logic [63:0] wd, input logic [2:0] op,
                        input logic w, input logic [127:0] sb, input int req_lat,
                        input int rsp_lat, input logic [63:0] rd, input logic re,
                        output int cycles, output bit saw_req, output bit stable,
                        output bit busy_ok, output logic [63:0] q_addr,
                        output logic [63:0] q_wdata, output logic [7:0] q_wstrb,
                        output logic q_we, output logic q_mmio);
    int phase;
    int cnt;
    cycles = -1; saw_req = 0; stable = 1; busy_ok = 1;
    q_addr = '0; q_wdata = '0; q_wstrb = '0; q_we = 0; q_mmio = 0;
    phase = 0; cnt = 0;
    @(negedge clk);
    addr = a; wdata = wd; mem_op = op; we = w; sb_i = sb;
    exu_valid = 1; wb_ready = 0;
    @(posedge clk);
    #1 exu_valid = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (lsu_valid) begin
        cycles = c;
        break;
      end
      if (lsu_ready !== 1'b0) busy_ok = 0;
      case (phase)
        0: if (req_valid) begin
          if (!saw_req) begin
            saw_req = 1;
            q_addr = req_addr; q_wdata = req_wdata; q_wstrb = req_wstrb;
            q_we = req_we; q_mmio = req_mmio;
          end else if (q_addr !== req_addr || q_wdata !== req_wdata ||
                       q_wstrb !== req_wstrb || q_we !== req_we || q_mmio !== req_mmio) begin
            stable = 0;
          end
          if (cnt < req_lat) begin
            req_ready = 0; cnt++;
          end else begin
            req_ready = 1; phase = 1; cnt = 0;
          end
        end
        1: begin
          req_ready = 0;
          if (cnt < rsp_lat) cnt++;
          else begin
            rsp_valid = 1; rsp_data = rd; rsp_err = re; phase = 2;
          end
        end
        2: begin
          rsp_valid = 0; rsp_data = {$urandom, $urandom}; phase = 3;
        end
        default: ;
      endcase
    end
    req_ready = 0; rsp_valid = 0; rsp_err = 0;
  endtask

  task automatic release_result;
    @(negedge clk);
    wb_ready = 1;
    @(posedge clk);
    #1 wb_ready = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    exu_valid = 0; addr = '0; wdata = '0; mem_op = '0; we = 0; sb_i = '0;
    wb_ready = 0; req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_err = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lsu_valid, req_valid, misalign_o, bus_err_o, mmio_o} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=00000",
               {lsu_valid, req_valid, misalign_o, bus_err_o, mmio_o});
    end
    checks++;
    if (dataout !== 64'd0 || alures_o !== 64'd0 || sb_o !== 128'd0) begin
      failures++;
      $display("[TB] FAIL reset_data got dataout=%h alures=%h sb=%h exp=0", dataout, alures_o, sb_o);
    end
    checks++;
    if (lsu_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b exp=1", lsu_ready);
    end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_load_byte;
    int cyc; bit sr, st, bo; logic [63:0] qa, qd; logic [7:0] qs; logic qw, qm;
    run_op(64'h8000_0003, 64'd0, 3'd1, 1'b0, 128'hA5, 0, 0, 64'h0000_0000_8000_0000, 1'b0,
           cyc, sr, st, bo, qa, qd, qs, qw, qm);
    checks++;
    if (dataout !== 64'hFFFF_FFFF_FFFF_FF80) begin
      failures++; $display("[TB] FAIL lb_data got=%h exp=ffffffffffffff80", dataout);
    end
    checks++;
    if (cyc !== 3) begin
      failures++; $display("[TB] FAIL lb_latency got=%0d exp=3", cyc);
    end
    checks++;
    if (qa !== 64'h8000_0000 || qw !== 1'b0 || sr !== 1'b1) begin
      failures++; $display("[TB] FAIL lb_req got addr=%h we=%b seen=%b exp 80000000/0/1", qa, qw, sr);
    end
    checks++;
    if (alures_o !== 64'h8000_0003 || sb_o !== 128'hA5) begin
      failures++; $display("[TB] FAIL lb_side got alures=%h sb=%h", alures_o, sb_o);
    end
    release_result();
  endtask

  task automatic test_store_half;
    int cyc; bit sr, st, bo; logic [63:0] qa, qd; logic [7:0] qs; logic qw, qm;
    run_op(64'h8000_0006, 64'h1234, 3'd2, 1'b1, 128'h5, 0, 0, 64'hDEAD_BEEF_0000_0000, 1'b0,
           cyc, sr, st, bo, qa, qd, qs, qw, qm);
    checks++;
    if (qd !== 64'h1234_0000_0000_0000 || qs !== 8'hC0) begin
      failures++; $display("[TB] FAIL sh_lane got wdata=%h wstrb=%h exp 1234000000000000/c0", qd, qs);
    end
    checks++;
    if (qa !== 64'h8000_0000 || qw !== 1'b1) begin
      failures++; $display("[TB] FAIL sh_req got addr=%h we=%b exp 80000000/1", qa, qw);
    end
    checks++;
    if (dataout !== 64'd0) begin
      failures++; $display("[TB] FAIL sh_dataout got=%h exp=0", dataout);
    end
    release_result();
  endtask

  task automatic test_misalign;
    int cyc; bit sr, st, bo; logic [63:0] qa, qd; logic [7:0] qs; logic qw, qm;
    run_op(64'h8000_0002, 64'd0, 3'd3, 1'b0, 128'h7, 0, 0, 64'd0, 1'b0,
           cyc, sr, st, bo, qa, qd, qs, qw, qm);
    checks++;
    if (sr !== 1'b0 || cyc !== 1 || misalign_o !== 1'b1) begin
      failures++; $display("[TB] FAIL lw_misalign got req=%b cyc=%0d mis=%b exp 0/1/1", sr, cyc, misalign_o);
    end
    release_result();
  endtask

  task automatic test_mmio_stall;
    int cyc; bit sr, st, bo; logic [63:0] qa, qd, rd; logic [7:0] qs; logic qw, qm;
    rd = {$urandom, $urandom};
    run_op(64'h0200_BFF8, 64'd0, 3'd4, 1'b0, 128'h9, 4, 0, rd, 1'b0,
           cyc, sr, st, bo, qa, qd, qs, qw, qm);
    checks++;
    if (qm !== 1'b1 || mmio_o !== 1'b1) begin
      failures++; $display("[TB] FAIL ld_mmio got req_mmio=%b mmio=%b exp 1/1", qm, mmio_o);
    end
    checks++;
    if (st !== 1'b1 || bo !== 1'b1) begin
      failures++; $display("[TB] FAIL ld_stall got stable=%b ready_low=%b exp 1/1", st, bo);
    end
    checks++;
    if (cyc !== 7 || dataout !== rd) begin
      failures++; $display("[TB] FAIL ld_result got cyc=%0d data=%h exp 7/%h", cyc, dataout, rd);
    end
    release_result();
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    mem_op = 3'd0; we = 0; exu_valid = 1; wb_ready = 1; sb_i = 128'd1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (lsu_valid !== 1'b1 || sb_o !== 128'(k)) begin
        failures++; $display("[TB] FAIL b2b_op%0d got valid=%b sb=%0d exp 1/%0d", k, lsu_valid, sb_o, k);
      end
      sb_i = 128'(k + 1);
    end
    wb_ready = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (lsu_ready !== 1'b0) begin
        failures++; $display("[TB] FAIL b2b_stall_ready got=%b exp=0", lsu_ready);
      end
      @(negedge clk);
      checks++;
      if (lsu_valid !== 1'b1 || sb_o !== 128'd3) begin
        failures++; $display("[TB] FAIL b2b_hold got valid=%b sb=%0d exp 1/3", lsu_valid, sb_o);
      end
    end
    exu_valid = 0;
    release_result();
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    addr = 64'h8000_0010; mem_op = 3'd3; we = 0; exu_valid = 1; wb_ready = 0;
    @(posedge clk);
    #1 exu_valid = 0;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_mid_req got=%b exp=1", req_valid);
    end
    req_ready = 1;
    @(negedge clk);
    req_ready = 0;
    rst = 0;
    #1;
    checks++;
    if (lsu_valid !== 1'b0 || req_valid !== 1'b0 || lsu_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_mid_idle got valid=%b req=%b ready=%b exp 0/0/1",
                           lsu_valid, req_valid, lsu_ready);
    end
    @(negedge clk);
    rst = 1;
    rsp_valid = 1; rsp_data = 64'h1111_2222_3333_4444;
    @(negedge clk);
    rsp_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (lsu_valid !== 1'b0 || req_valid !== 1'b0 || dataout !== 64'd0) begin
      failures++; $display("[TB] FAIL rst_mid_stale got valid=%b req=%b data=%h exp 0/0/0",
                           lsu_valid, req_valid, dataout);
    end
  endtask

  task automatic test_random;
    int cyc; bit sr, st, bo; logic [63:0] qa, qd; logic [7:0] qs; logic qw, qm;
    logic [63:0] a, wd, rd; logic [2:0] op; logic w, re; logic [127:0] sb;
    int rl, pl, size, off, sel; bit mis, store, mm;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 2);
      if (sel == 0)      a = MBASE - 64'd8 + 64'($urandom_range(0, 15));
      else if (sel == 1) a = MLIMIT - 64'd7 + 64'($urandom_range(0, 15));
      else               a = {32'd0, $urandom};
      wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      re = 1'($urandom_range(0, 1)); sb = {$urandom, $urandom, $urandom, $urandom};
      rl = $urandom_range(0, 3); pl = $urandom_range(0, 2);
      size  = op_size(op);
      off   = int'(a % 8);
      mis   = (size != 0) && ((a % 64'(size)) != 0);
      store = w && (op >= 3'd1) && (op <= 3'd4);
      mm    = (a >= MBASE) && (a <= MLIMIT);
      run_op(a, wd, op, w, sb, rl, pl, rd, re, cyc, sr, st, bo, qa, qd, qs, qw, qm);
      checks++;
      if (alures_o !== a || sb_o !== sb || mmio_o !== mm || misalign_o !== mis) begin
        failures++;
        $display("[TB] FAIL rnd%0d_side got a=%h mm=%b mis=%b exp a=%h mm=%b mis=%b",
                 n, alures_o, mmio_o, misalign_o, a, mm, mis);
      end
      if (size == 0 || mis) begin
        checks++;
        if (cyc !== 1 || sr !== 1'b0 || dataout !== 64'd0 || bus_err_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rnd%0d_nomem got cyc=%0d req=%b data=%h err=%b exp 1/0/0/0",
                   n, cyc, sr, dataout, bus_err_o);
        end
      end else begin
        checks++;
        if (cyc !== 3 + rl + pl || sr !== 1'b1 || st !== 1'b1 || bo !== 1'b1) begin
          failures++;
          $display("[TB] FAIL rnd%0d_timing got cyc=%0d req=%b stable=%b busy=%b exp %0d/1/1/1",
                   n, cyc, sr, st, bo, 3 + rl + pl);
        end
        checks++;
        if (qa !== (a & ~64'd7) || qw !== store || qm !== mm || bus_err_o !== re) begin
          failures++;
          $display("[TB] FAIL rnd%0d_req got addr=%h we=%b mmio=%b err=%b exp %h/%b/%b/%b",
                   n, qa, qw, qm, bus_err_o, a & ~64'd7, store, mm, re);
        end
        checks++;
        if (store) begin
          if (qd !== model_store(wd, off) || qs !== model_strb(off, size) || dataout !== 64'd0) begin
            failures++;
            $display("[TB] FAIL rnd%0d_store got wdata=%h strb=%h data=%h exp %h/%h/0",
                     n, qd, qs, dataout, model_store(wd, off), model_strb(off, size));
          end
        end else if (dataout !== model_load(rd, off, size, op <= 3'd4)) begin
          failures++;
          $display("[TB] FAIL rnd%0d_load got=%h exp=%h", n, dataout,
                   model_load(rd, off, size, op <= 3'd4));
        end
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_mmio_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
